spi_device_tx_ml: RTL and testbench
===================================

Name: spi_device_tx_ml

Overview:
- Parametrised multi-lane SPI device transmitter running entirely on the system clock; replaces the sclk-clocked single-word transmitter.
- Synchronises the external sclk/cs pins, detects sclk edges, and shifts a DATA_W-bit word MSB-first over 1, 2 or 4 lanes.
- A one-entry holding buffer with valid/ready handshake allows back-to-back words without gaps.
- Sits between the SPI slave controller (beat target, lane mode) and the register/FIFO read path (data).

Parameters:
- DATA_W, 32, shift word width; multiple of 4, at least 8.
- CNT_W, 8, beat counter and target width.
- DEF_TGT, 7, beat target loaded while cs is high (last beat index).
- SYNC_STAGES, 2, synchroniser depth for spi_sclk and spi_cs; at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- spi_sclk  in  1  SPI clock pin, asynchronous to clk.
- spi_cs  in  1  SPI chip select pin, active low, asynchronous to clk.
- lane_mode  in  2  00 single, 01 dual, 10 quad, 11 reserved (treated as single).
- cnt_tgt  in  CNT_W  last beat index of the word (beats minus 1).
- cnt_upd  in  1  1-cycle strobe: load cnt_tgt and start or continue transmitting.
- data  in  DATA_W  next word to send.
- data_valid  in  1  data is valid.
- data_ready  out  1  holding buffer is empty.
- sdo  out  4  serial data lanes.
- sdo_oe  out  4  per-lane output enable.
- done  out  1  1-cycle pulse when the last beat of a word is shifted.
- underrun  out  1  1-cycle pulse when a word ends in RUN with no queued word.
- abort  out  1  1-cycle pulse when cs deasserts mid-word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE. Counter=0, target=DEF_TGT, shift register=0, holding buffer empty.
  - Synchronisers are preset to sclk=0, cs=1.
  - Outputs: sdo=0, sdo_oe=0, data_ready=1, done=0, underrun=0, abort=0.
  - Reset overrides every other event, including one arriving mid-word.
- Synchronisation and edges:
  - sclk and cs each pass through SYNC_STAGES flops.
  - A shift edge is a synchronised sclk 1->0 transition; it is a 1-clk strobe.
  - Pin-to-strobe latency is SYNC_STAGES+1 clk cycles.
  - clk must be at least 4x the sclk frequency.
- State machine:
  - IDLE: entered while synchronised cs=1. Counter=0, target=DEF_TGT, shift register=0, sdo_oe=0.
  - IDLE->ARMED on synchronised cs 1->0. lane_mode is latched at this transition and held until cs rises.
  - ARMED: sdo_oe is set for the active lanes (lane 0; lanes 0-1; or lanes 0-3). sdo=0. Shift edges are ignored.
  - ARMED->RUN on cnt_upd. Target<=cnt_tgt. If the holding buffer is full, the shift register loads from it and the buffer empties in the same cycle; otherwise the shift register loads 0.
  - RUN, shift edge with counter!=target: counter+1; shift register shifts left by L (L=1, 2 or 4), zero-filled.
  - RUN, shift edge with counter==target: done=1; counter=0.
    - Holding buffer full: load the shift register from it and stay in RUN.
    - Holding buffer empty: go to ARMED, shift register=0, underrun=1.
  - cnt_upd in RUN: target<=cnt_tgt. Counter is unchanged and the new target applies to the current word. If it coincides with a word-end edge, the new target applies to the next word.
  - Any state, synchronised cs 1->0->1 rise: go to IDLE next cycle and flush the holding buffer. abort=1 if the state was RUN with counter!=0; otherwise abort=0. done is not asserted.
- Data mapping, taken from the shift register MSBs:
  - Single: sdo[0]=sr[DATA_W-1].
  - Dual: sdo[1:0]=sr[DATA_W-1:DATA_W-2].
  - Quad: sdo[3:0]=sr[DATA_W-1:DATA_W-4].
  - Unused lanes drive 0.
- Handshake:
  - A word is accepted when data_valid&&data_ready at a clk edge.
  - data_ready = holding buffer empty. A buffer load and a buffer drain in the same cycle are allowed.
  - When data_valid=1 and data_ready=0, the word is not taken; the source must hold it.
- Counter wrap: the counter compares for equality only; target=2^CNT_W-1 is legal. There is no implicit wrap past the target.

Optional Feature:
- Macro: SPI_TX_TEST_EDGE_EN.
- Defined: adds input port test_mode (1 bit). When test_mode=1, the shift edge becomes a synchronised sclk 0->1 transition; everything else is unchanged.
- Undefined: no test_mode port; the shift edge is always sclk falling.

Test Plan:
- Single lane, DATA_W=32: push 0xA5A5_0F0F, drop cs, cnt_upd with tgt=31, 32 sclk falls -> sdo[0] emits 1010_0101... MSB first; done pulses once on the 32nd edge; then underrun=1 and state ARMED.
- Quad lane, tgt=7: queue 0x1234_5678 then 0x9ABC_DEF0 -> sdo[3:0] nibbles 1,2,...,8 then 9,A,...,0 with no gap; two done pulses; data_ready returns to 1 after each reload.
- Dual lane, tgt=15: cnt_upd with tgt=3 after beat 2 -> done at beat 3, counter 0; the next word uses tgt=3.
- cs rises after 5 beats in quad mode -> abort=1 for one cycle, sdo_oe=0, data_ready=1, counter=0, target=7; no done.
- rst=1 mid-word with holding buffer full -> all outputs at reset values on the next clk; buffer empty.
- With SPI_TX_TEST_EDGE_EN defined and test_mode=1: single lane, tgt=7, data=0x8000_0000 -> sdo[0] updates after sclk rising edges; done on the 8th rise.

Source files
------------

// File: rtl/spi_device_tx_ml.sv
// spi_device_tx_ml: multi-lane (1/2/4) SPI device transmitter clocked by the system clock.
// Synchronises sclk/cs, detects sclk edges and shifts a DATA_W word MSB-first, fed
// through a one-entry holding buffer with a valid/ready handshake.
// Optional: define SPI_TX_TEST_EDGE_EN to add the test_mode input, which moves the
// shift edge from synchronised sclk falling to synchronised sclk rising.
module spi_device_tx_ml #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEF_TGT     = 7,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SPI_TX_TEST_EDGE_EN
   input  logic              test_mode,
`endif
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic [1:0]        lane_mode,
   input  logic [CNT_W-1:0]  cnt_tgt,
   input  logic              cnt_upd,
   input  logic [DATA_W-1:0] data,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [3:0]        sdo,
   output logic [3:0]        sdo_oe,
   output logic              done,
   output logic              underrun,
   output logic              abort
);

   localparam logic [1:0] LaneSingle = 2'b00;
   localparam logic [1:0] LaneDual   = 2'b01;
   localparam logic [1:0] LaneQuad   = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StRun
   } state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
   logic                    sclk_prev_q, sclk_prev_d;
   logic                    cs_prev_q, cs_prev_d;
   logic [1:0]              lane_q, lane_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        tgt_q, tgt_d;
   logic [DATA_W-1:0]       sr_q, sr_d;
   logic [DATA_W-1:0]       buf_q, buf_d;
   logic                    buf_full_q, buf_full_d;
   logic                    done_q, done_d;
   logic                    underrun_q, underrun_d;
   logic                    abort_q, abort_d;

   logic                    sclk_s;
   logic                    cs_s;
   logic                    shift_edge;
   logic                    cs_fall;
   logic                    cs_rise;
   logic                    buf_drain;
   logic                    buf_flush;
   logic [1:0]              lane_norm;
   logic [DATA_W-1:0]       sr_shifted;

   // Pin synchronisers and edge detection against the previous synchronised value.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      cs_s        = cs_sync_q[SYNC_STAGES-1];
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      cs_fall     = cs_prev_q & ~cs_s;
      cs_rise     = ~cs_prev_q & cs_s;
`ifdef SPI_TX_TEST_EDGE_EN
      shift_edge  = test_mode ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);
`else
      shift_edge  = sclk_prev_q & ~sclk_s;
`endif
   end

   // Lane-mode normalisation (reserved encoding behaves as single) and the per-beat shift.
   always_comb begin
      lane_norm = (lane_mode == 2'b11) ? LaneSingle : lane_mode;
      case (lane_q)
         LaneDual: sr_shifted = sr_q << 2;
         LaneQuad: sr_shifted = sr_q << 4;
         default:  sr_shifted = sr_q << 1;
      endcase
   end

   // Transmit state machine: next state, counter/target, shift register and status pulses.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      sr_d       = sr_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
      buf_drain  = 1'b0;
      buf_flush  = 1'b0;

      if (cs_rise) begin
         // cs release wins over any in-flight beat; no done for a truncated word.
         state_d   = StIdle;
         buf_flush = 1'b1;
         abort_d   = (state_q == StRun) && (cnt_q != '0);
         cnt_d     = '0;
         tgt_d     = CNT_W'(DEF_TGT);
         sr_d      = '0;
      end else begin
         case (state_q)
            StIdle: begin
               cnt_d = '0;
               tgt_d = CNT_W'(DEF_TGT);
               sr_d  = '0;
               if (cs_fall) begin
                  state_d = StArmed;
                  lane_d  = lane_norm;
               end
            end
            StArmed: begin
               sr_d = '0;
               if (cnt_upd) begin
                  state_d = StRun;
                  tgt_d   = cnt_tgt;
                  cnt_d   = '0;
                  if (buf_full_q) begin
                     sr_d      = buf_q;
                     buf_drain = 1'b1;
                  end
               end
            end
            StRun: begin
               // A target update racing a word end is compared next word, since the
               // compare below still uses tgt_q.
               if (cnt_upd) begin
                  tgt_d = cnt_tgt;
               end
               if (shift_edge) begin
                  if (cnt_q != tgt_q) begin
                     cnt_d = cnt_q + CNT_W'(1);
                     sr_d  = sr_shifted;
                  end else begin
                     done_d = 1'b1;
                     cnt_d  = '0;
                     if (buf_full_q) begin
                        sr_d      = buf_q;
                        buf_drain = 1'b1;
                     end else begin
                        state_d    = StArmed;
                        sr_d       = '0;
                        underrun_d = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // One-entry holding buffer; a cs-release flush takes priority over a same-cycle accept.
   always_comb begin
      data_ready = ~buf_full_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      if (buf_flush) begin
         buf_full_d = 1'b0;
      end else begin
         if (buf_drain) begin
            buf_full_d = 1'b0;
         end
         if (data_valid && data_ready) begin
            buf_d      = data;
            buf_full_d = 1'b1;
         end
      end
   end

   // Lane output mapping from the shift register MSBs; unused lanes drive 0.
   always_comb begin
      case (lane_q)
         LaneDual: sdo = {2'b00, sr_q[DATA_W-1 -: 2]};
         LaneQuad: sdo = sr_q[DATA_W-1 -: 4];
         default:  sdo = {3'b000, sr_q[DATA_W-1]};
      endcase
      if (state_q == StIdle) begin
         sdo_oe = 4'b0000;
      end else begin
         case (lane_q)
            LaneDual: sdo_oe = 4'b0011;
            LaneQuad: sdo_oe = 4'b1111;
            default:  sdo_oe = 4'b0001;
         endcase
      end
      done     = done_q;
      underrun = underrun_q;
      abort    = abort_q;
   end

   // State registers with synchronous reset; synchronisers preset to sclk=0, cs=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         lane_q      <= LaneSingle;
         cnt_q       <= '0;
         tgt_q       <= CNT_W'(DEF_TGT);
         sr_q        <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         sr_q        <= sr_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
      end
   end

endmodule

// File: tb/tb_spi_device_tx_ml.sv
// tb_spi_device_tx_ml: directed bench for spi_device_tx_ml (DATA_W=32, CNT_W=8, DEF_TGT=7).
// sclk runs at 8 clk cycles per period; sdo is sampled late in the sclk high phase.
module tb_spi_device_tx_ml;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              spi_sclk;
   logic              spi_cs;
   logic [1:0]        lane_mode;
   logic [CNT_W-1:0]  cnt_tgt;
   logic              cnt_upd;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;
   logic [3:0]        sdo;
   logic [3:0]        sdo_oe;
   logic              done;
   logic              underrun;
   logic              abort;
`ifdef SPI_TX_TEST_EDGE_EN
   logic              test_mode;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned done_cnt = 0;
   int unsigned underrun_cnt = 0;
   int unsigned abort_cnt = 0;

   spi_device_tx_ml #(
      .DATA_W      (DATA_W),
      .CNT_W       (CNT_W),
      .DEF_TGT     (7),
      .SYNC_STAGES (2)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
`ifdef SPI_TX_TEST_EDGE_EN
      .test_mode  (test_mode),
`endif
      .spi_sclk   (spi_sclk),
      .spi_cs     (spi_cs),
      .lane_mode  (lane_mode),
      .cnt_tgt    (cnt_tgt),
      .cnt_upd    (cnt_upd),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sdo        (sdo),
      .sdo_oe     (sdo_oe),
      .done       (done),
      .underrun   (underrun),
      .abort      (abort)
   );

   always #5 clk = ~clk;

   // Pulse counters: a 1-cycle pulse is seen on exactly one falling clk edge.
   always @(negedge clk) begin
      if (done)     done_cnt++;
      if (underrun) underrun_cnt++;
      if (abort)    abort_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      int unsigned k = 0;
      while (!data_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("push_ready", 64'(data_ready), 64'h1);
      data       = w;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic upd(input logic [CNT_W-1:0] t);
      cnt_tgt = t;
      cnt_upd = 1'b1;
      @(negedge clk);
      cnt_upd = 1'b0;
   endtask

   task automatic cs_low(input logic [1:0] mode);
      lane_mode = mode;
      spi_cs    = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // One sclk period, sampling sdo just before the falling edge.
   task automatic beat(output logic [3:0] s);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      s        = sdo;
      spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [3:0]  s;
      logic [31:0] w32;
      logic [63:0] w64;
      logic [15:0] w16;
      logic [2:0]  hi_lanes;
      int unsigned d0, u0, a0;

      rst        = 1'b1;
      spi_sclk   = 1'b0;
      spi_cs     = 1'b1;
      lane_mode  = 2'b00;
      cnt_tgt    = '0;
      cnt_upd    = 1'b0;
      data       = '0;
      data_valid = 1'b0;
`ifdef SPI_TX_TEST_EDGE_EN
      test_mode  = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_sdo", 64'(sdo), 64'h0);
      check("rst_sdo_oe", 64'(sdo_oe), 64'h0);
      check("rst_ready", 64'(data_ready), 64'h1);
      check("rst_done", 64'(done), 64'h0);
      check("rst_underrun", 64'(underrun), 64'h0);
      check("rst_abort", 64'(abort), 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single lane, one 32-bit word, then underrun.
      d0 = done_cnt; u0 = underrun_cnt; a0 = abort_cnt;
      push(32'hA5A5_0F0F);
      check("t1_full", 64'(data_ready), 64'h0);
      cs_low(2'b00);
      check("t1_armed_oe", 64'(sdo_oe), 64'h1);
      check("t1_armed_sdo", 64'(sdo), 64'h0);
      upd(8'd31);
      check("t1_drained", 64'(data_ready), 64'h1);
      w32 = '0; hi_lanes = '0;
      for (int i = 0; i < 32; i++) begin
         beat(s);
         w32 = {w32[30:0], s[0]};
         hi_lanes = hi_lanes | s[3:1];
         if (i == 30) check("t1_no_early_done", 64'(done_cnt - d0), 64'd0);
      end
      check("t1_word", 64'(w32), 64'hA5A5_0F0F);
      check("t1_unused_lanes", 64'(hi_lanes), 64'h0);
      check("t1_done", 64'(done_cnt - d0), 64'd1);
      check("t1_underrun", 64'(underrun_cnt - u0), 64'd1);
      check("t1_after_sdo", 64'(sdo), 64'h0);
      check("t1_after_oe", 64'(sdo_oe), 64'h1);
      cs_high();
      check("t1_no_abort", 64'(abort_cnt - a0), 64'd0);
      check("t1_idle_oe", 64'(sdo_oe), 64'h0);

      // Quad lane, two back-to-back words; a push while full must be ignored.
      d0 = done_cnt; u0 = underrun_cnt; a0 = abort_cnt;
      push(32'h1234_5678);
      cs_low(2'b10);
      upd(8'd7);
      push(32'h9ABC_DEF0);
      check("t2_full", 64'(data_ready), 64'h0);
      data = 32'hFFFF_FFFF; data_valid = 1'b1;
      repeat (2) @(negedge clk);
      data_valid = 1'b0;
      w64 = '0;
      for (int i = 0; i < 16; i++) begin
         beat(s);
         w64 = {w64[59:0], s};
         if (i == 7) begin
            check("t2_done_w1", 64'(done_cnt - d0), 64'd1);
            check("t2_ready_reload", 64'(data_ready), 64'h1);
         end
      end
      check("t2_words", w64, 64'h1234_5678_9ABC_DEF0);
      check("t2_done", 64'(done_cnt - d0), 64'd2);
      check("t2_underrun", 64'(underrun_cnt - u0), 64'd1);
      check("t2_oe", 64'(sdo_oe), 64'hF);
      cs_high();
      check("t2_idle_oe", 64'(sdo_oe), 64'h0);
      check("t2_no_abort", 64'(abort_cnt - a0), 64'd0);

      // Dual lane: target shortened mid-word to 3; next word keeps target 3.
      d0 = done_cnt; u0 = underrun_cnt;
      push(32'h1B00_0000);
      cs_low(2'b01);
      upd(8'd15);
      push(32'hE400_0000);
      check("t3_oe", 64'(sdo_oe), 64'h3);
      w16 = '0;
      for (int i = 0; i < 8; i++) begin
         beat(s);
         w16 = {w16[13:0], s[1:0]};
         if (i == 1) upd(8'd3);
         if (i == 2) check("t3_no_done_b2", 64'(done_cnt - d0), 64'd0);
         if (i == 3) check("t3_done_b3", 64'(done_cnt - d0), 64'd1);
         if (i == 6) check("t3_w2_short", 64'(done_cnt - d0), 64'd1);
      end
      check("t3_dibits", 64'(w16), 64'h1BE4);
      check("t3_done", 64'(done_cnt - d0), 64'd2);
      check("t3_underrun", 64'(underrun_cnt - u0), 64'd1);
      cs_high();

      // Quad lane, cs released after 5 beats with a word queued.
      d0 = done_cnt; a0 = abort_cnt;
      push(32'hFFFF_FFFF);
      cs_low(2'b10);
      upd(8'd7);
      push(32'h0F0F_0F0F);
      for (int i = 0; i < 5; i++) beat(s);
      check("t4_sdo_mid", 64'(sdo), 64'hF);
      cs_high();
      check("t4_abort", 64'(abort_cnt - a0), 64'd1);
      check("t4_no_done", 64'(done_cnt - d0), 64'd0);
      check("t4_oe", 64'(sdo_oe), 64'h0);
      check("t4_sdo", 64'(sdo), 64'h0);
      check("t4_flushed", 64'(data_ready), 64'h1);

      // Reset mid-word with the holding buffer full.
      push(32'hAAAA_0000);
      cs_low(2'b10);
      upd(8'd7);
      push(32'h5555_5555);
      beat(s);
      beat(s);
      check("t5_pre_sdo", 64'(sdo), 64'hA);
      check("t5_pre_full", 64'(data_ready), 64'h0);
      rst = 1'b1;
      @(negedge clk);
      check("t5_sdo", 64'(sdo), 64'h0);
      check("t5_oe", 64'(sdo_oe), 64'h0);
      check("t5_ready", 64'(data_ready), 64'h1);
      check("t5_done", 64'(done), 64'h0);
      check("t5_underrun", 64'(underrun), 64'h0);
      check("t5_abort", 64'(abort), 64'h0);
      rst = 1'b0;
      cs_high();

`ifdef SPI_TX_TEST_EDGE_EN
      // Test mode: shift on sclk rising; sample just before each rise.
      d0 = done_cnt;
      test_mode = 1'b1;
      push(32'h8000_0000);
      cs_low(2'b00);
      upd(8'd7);
      w32 = '0;
      for (int i = 0; i < 8; i++) begin
         s        = sdo;
         w32      = {w32[30:0], s[0]};
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
         repeat (4) @(negedge clk);
         if (i == 6) check("t6_no_early_done", 64'(done_cnt - d0), 64'd0);
      end
      check("t6_bits", 64'(w32[7:0]), 64'h80);
      check("t6_done", 64'(done_cnt - d0), 64'd1);
      cs_high();
      test_mode = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
